// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and helpers for the AXI-Stream packet arbiters.
//   arb_state_e : arbiter FSM state (ARB = choosing a source, XFER = packet owned)
//   clog2()     : elaboration-time ceil(log2), minimum 1 so it can size a vector
//   DEF_*       : default geometry (4 sources, 64-bit stream)
// -----------------------------------------------------------------------------
package axis_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int DEF_N_SRC  = 4;
  localparam int DEF_DATA_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// -----------------------------------------------------------------------------
// axis_rr_pick
// Combinational rotating-priority encoder. The request just after last_i has
// the highest priority, wrapping modulo N.
//   req_i   [N-1:0]  request vector
//   last_i  [W-1:0]  index of the previous winner (< N)
//   grant_o [W-1:0]  index of the winner (0 when nothing requests)
//   any_o            at least one request present
// -----------------------------------------------------------------------------
module axis_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] grant_o,
  output logic         any_o
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  int             pos;

  always_comb begin
    // Rotate so that bit 0 of rot is the source right after the last winner.
    req2    = {req_i, req_i} >> (int'(last_i) + 1);
    rot     = req2[N-1:0];
    pos     = 0;
    any_o   = 1'b0;
    grant_o = '0;
    for (int j = 0; j < N; j++) begin
      if (!any_o && rot[j]) begin
        any_o = 1'b1;
        pos   = j;
      end
    end
    if (any_o) grant_o = W'((int'(last_i) + 1 + pos) % N);
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_pkt_rr_arbiter
// Packet-granular round-robin merge of N_SRC AXI-Stream sources onto one
// master stream. The grant is held from first beat to tlast, so packets are
// never interleaved. One idle (ARB) cycle separates consecutive packets.
//   AXI_CLk, AXI_RSTN       clock, asynchronous active-low reset
//   src_en                  per-source arbitration enable
//   s_t{data,keep,last,valid} / s_tready   flattened source streams
//   m_t{data,keep,last,valid} / m_tready   merged stream, m_tid = owning source
//   pkt_cnt                 32-bit completed-packet counter per source
//   err_overlen / err_clr   sticky over-length flag per source, sync clear
// -----------------------------------------------------------------------------
module axis_pkt_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int N_SRC         = DEF_N_SRC,
  parameter  int DATA_W        = DEF_DATA_W,
  parameter  int ID_W          = clog2(N_SRC),
  parameter  int MAX_PKT_BEATS = 65536,
  localparam int KEEP_W        = DATA_W / 8
) (
  input  logic                       AXI_CLk,
  input  logic                       AXI_RSTN,
  input  logic [N_SRC-1:0]           src_en,
  input  logic [N_SRC*DATA_W-1:0]    s_tdata,
  input  logic [N_SRC*KEEP_W-1:0]    s_tkeep,
  input  logic [N_SRC-1:0]           s_tlast,
  input  logic [N_SRC-1:0]           s_tvalid,
  output logic [N_SRC-1:0]           s_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic [KEEP_W-1:0]          m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [ID_W-1:0]            m_tid,
  output logic [N_SRC*32-1:0]        pkt_cnt,
  output logic [N_SRC-1:0]           err_overlen,
  input  logic                       err_clr
);

  localparam int              CNT_W      = clog2(MAX_PKT_BEATS);
  localparam logic [CNT_W-1:0] BEAT_LIMIT = CNT_W'(MAX_PKT_BEATS - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]      pkt_cnt_q [N_SRC];
  logic [31:0]      pkt_cnt_d [N_SRC];
  logic             err_q [N_SRC];
  logic             err_d [N_SRC];

  logic [ID_W-1:0]  pick_grant;
  logic             pick_any;
  logic             beat_acc;
  logic             pkt_done;
  logic             overlen_hit;

  axis_rr_pick #(
    .N (N_SRC),
    .W (ID_W)
  ) u_pick (
    .req_i   (s_tvalid & src_en),
    .last_i  (last_grant_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  // Zero-latency datapath: the granted source is wired straight through.
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    m_tvalid = 1'b0;
    s_tready = '0;
    if (state_q == XFER) begin
      m_tdata            = s_tdata[int'(grant_q)*DATA_W +: DATA_W];
      m_tkeep            = s_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
      m_tlast            = s_tlast[grant_q];
      m_tvalid           = s_tvalid[grant_q];
      s_tready[grant_q]  = m_tready;
    end
  end

  assign beat_acc = m_tvalid & m_tready;
  assign m_tid    = grant_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_done     = 1'b0;
    overlen_hit  = 1'b0;
    case (state_q)
      ARB: begin
        if (pick_any) begin
          grant_d = pick_grant;
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat_acc) begin
          if (m_tlast) begin
            pkt_done     = 1'b1;
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            state_d      = ARB;
          end else if (beat_cnt_q == BEAT_LIMIT) begin
            // Counter saturates; every further non-last beat re-asserts the flag.
            overlen_hit = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge AXI_CLk or negedge AXI_RSTN) begin
    if (!AXI_RSTN) begin
      state_q      <= ARB;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N_SRC - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    logic owner;
    assign owner = (grant_q == ID_W'(gi));

    assign pkt_cnt_d[gi] = (pkt_done && owner) ? pkt_cnt_q[gi] + 32'd1 : pkt_cnt_q[gi];
    // A new over-length event beats a simultaneous clear.
    assign err_d[gi]     = (overlen_hit && owner) ? 1'b1 :
                           (err_clr ? 1'b0 : err_q[gi]);

    always_ff @(posedge AXI_CLk or negedge AXI_RSTN) begin
      if (!AXI_RSTN) begin
        pkt_cnt_q[gi] <= '0;
        err_q[gi]     <= 1'b0;
      end else begin
        pkt_cnt_q[gi] <= pkt_cnt_d[gi];
        err_q[gi]     <= err_d[gi];
      end
    end

    assign pkt_cnt[gi*32 +: 32] = pkt_cnt_q[gi];
    assign err_overlen[gi]      = err_q[gi];
  end

endmodule
